// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] w_k;

    // Scan from the farthest offset down so the nearest match to ptr wins.
    always_comb begin
        idx = ptr;
        w_k = ptr;
        any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_k = SEL_W'(int'(ptr) + i);
            if (req[w_k]) begin
                idx = w_k;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4x1.sv
// Round-robin arbiter driving a shared 4:1 data mux with bounded bursts.
// Optional per-requester grant counters are built when ARB_STATS_EN is defined.
module rr_mux_arbiter_4x1
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
`ifdef ARB_STATS_EN
    ,
    parameter int unsigned CNT_W     = 8
`endif
)
(
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [N_REQ-1:0]        req_in,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    ready_in,
    output logic [N_REQ-1:0]        gnt_out,
    output logic [SEL_W-1:0]        sel_out,
    output logic [DATA_W-1:0]       y_out,
    output logic                    valid_out
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]  grant_cnt_out
`endif
);

    localparam int unsigned BCNT_W = 8;

    arb_state_e        r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
    logic [BCNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_req_sel;
    logic              w_valid;

    rr_pick4 u_pick (
        .req (req_in),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_req_sel = req_in[r_sel];
    assign w_valid   = (r_state == GRANT) && w_req_sel;

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Next-state: pick in IDLE, count beats in GRANT, release on withdrawal or burst end.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_gnt_nxt      = r_gnt;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_sel_nxt      = w_pick_idx;
                    w_gnt_nxt      = idx2onehot(w_pick_idx);
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (!w_req_sel ||
                    (ready_in && (r_beat_cnt == BCNT_W'(MAX_BURST - 1)))) begin
                    w_gnt_nxt      = '0;
                    w_ptr_nxt      = r_sel + SEL_W'(1);
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = IDLE;
                end else if (ready_in) begin
                    w_beat_cnt_nxt = r_beat_cnt + BCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign gnt_out   = r_gnt;
    assign sel_out   = r_sel;
    assign valid_out = w_valid;
    assign y_out     = data_in[r_sel*DATA_W +: DATA_W];

`ifdef ARB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] r_gcnt;
    logic                        w_grant_evt;

    assign w_grant_evt = (r_state == IDLE) && w_pick_any;

    // Saturating per-requester grant counters, bumped on each new grant.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gcnt <= '0;
        end else if (w_grant_evt && (r_gcnt[w_pick_idx] != '1)) begin
            r_gcnt[w_pick_idx] <= r_gcnt[w_pick_idx] + CNT_W'(1);
        end
    end

    assign grant_cnt_out = r_gcnt;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// Bench for rr_mux_arbiter_4x1: directed scenarios plus randomized run against a reference model.
module tb_rr_mux_arbiter_4x1;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;
`ifdef ARB_STATS_EN
    localparam int unsigned CNT_W     = 2;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req_in;
    logic [4*DATA_W-1:0] data_in;
    logic                ready_in;
    logic [3:0]          gnt_out;
    logic [1:0]          sel_out;
    logic [DATA_W-1:0]   y_out;
    logic                valid_out;
`ifdef ARB_STATS_EN
    logic [4*CNT_W-1:0]  grant_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter_4x1 #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
`ifdef ARB_STATS_EN
        ,
        .CNT_W     (CNT_W)
`endif
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .req_in    (req_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .gnt_out   (gnt_out),
        .sel_out   (sel_out),
        .y_out     (y_out),
        .valid_out (valid_out)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt_out (grant_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: who holds the bus, beats delivered, rotation start.
    bit m_busy;
    int m_idx, m_sel, m_ptr, m_beats;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_in   = 4'b0000;
        ready_in = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_busy = 0; m_idx = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_clock();
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req_in[(m_ptr + k) % 4]) begin
                    m_busy  = 1;
                    m_idx   = (m_ptr + k) % 4;
                    m_sel   = m_idx;
                    m_beats = 0;
                end
            end
        end else if (!req_in[m_idx]) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 4;
        end else if (ready_in) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % 4;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req_in   = 4'b1111;
        ready_in = 1'b1;
        data_in  = 32'hA1B2C3D4;
        step();
        step();
        checks++;
        if (gnt_out !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got %b want 0000", gnt_out);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", valid_out);
        end
        checks++;
        if (sel_out !== 2'd0) begin
            errors++; $display("FAIL reset_sel got %0d want 0", sel_out);
        end
        checks++;
        if (y_out !== 8'hD4) begin
            errors++; $display("FAIL reset_y got %h want d4", y_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] exp_y;
        do_reset();
        data_in  = (4*DATA_W)'($urandom);
        exp_y    = data_in[2*DATA_W +: DATA_W];
        req_in   = 4'b0100;
        ready_in = 1'b1;
        checks++;
        if (gnt_out !== 4'b0000) begin
            errors++; $display("FAIL single_pre_gnt got %b want 0000", gnt_out);
        end
        step();
        checks++;
        if (gnt_out !== 4'b0100 || sel_out !== 2'd2) begin
            errors++; $display("FAIL single_grant got gnt=%b sel=%0d want 0100/2", gnt_out, sel_out);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (valid_out !== 1'b1 || y_out !== exp_y || gnt_out !== 4'b0100) begin
                errors++;
                $display("FAIL single_beat%0d got v=%b y=%h gnt=%b want 1/%h/0100", b, valid_out, y_out, gnt_out, exp_y);
            end
            step();
        end
        checks++;
        if (gnt_out !== 4'b0000 || valid_out !== 1'b0) begin
            errors++; $display("FAIL single_bubble got gnt=%b v=%b want 0000/0", gnt_out, valid_out);
        end
        step();
        checks++;
        if (gnt_out !== 4'b0100 || sel_out !== 2'd2) begin
            errors++; $display("FAIL single_regrant got gnt=%b sel=%0d want 0100/2", gnt_out, sel_out);
        end
    endtask

    task automatic test_all_requesting();
        int order [5] = '{0, 1, 2, 3, 0};
        int ng = 0, beats = 0, idle_len = 0;
        logic [3:0] prev = 4'b0000;
        do_reset();
        req_in   = 4'b1111;
        ready_in = 1'b1;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            step();
            if (gnt_out != 4'b0000) begin
                if (prev == 4'b0000) begin
                    if (ng > 0) begin
                        checks++;
                        if (idle_len != 1) begin
                            errors++; $display("FAIL all_bubble%0d got %0d want 1", ng, idle_len);
                        end
                    end
                    checks++;
                    if (sel_out !== 2'(order[ng])) begin
                        errors++; $display("FAIL all_order%0d got %0d want %0d", ng, sel_out, order[ng]);
                    end
                    ng++;
                    beats    = 0;
                    idle_len = 0;
                end
                if (valid_out && ready_in) beats++;
            end else begin
                if (prev != 4'b0000) begin
                    checks++;
                    if (beats != 4) begin
                        errors++; $display("FAIL all_beats%0d got %0d want 4", ng - 1, beats);
                    end
                end
                idle_len++;
            end
            prev = gnt_out;
        end
        checks++;
        if (ng != 5) begin
            errors++; $display("FAIL all_timeout got %0d grants want 5", ng);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        bit released = 0;
        do_reset();
        req_in   = 4'b0010;
        ready_in = 1'b0;
        step();
        checks++;
        if (gnt_out !== 4'b0010 || sel_out !== 2'd1) begin
            errors++; $display("FAIL bp_grant got gnt=%b sel=%0d want 0010/1", gnt_out, sel_out);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (valid_out !== 1'b1 || gnt_out !== 4'b0010) begin
                errors++; $display("FAIL bp_hold%0d got v=%b gnt=%b want 1/0010", c, valid_out, gnt_out);
            end
            step();
        end
        ready_in = 1'b1;
        for (int c = 0; c < 20 && !released; c++) begin
            if (gnt_out == 4'b0000) released = 1;
            else begin
                if (valid_out) beats++;
                step();
            end
        end
        checks++;
        if (!released || beats != 4) begin
            errors++; $display("FAIL bp_beats got %0d released=%0d want 4/1", beats, released);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req_in   = 4'b1000;
        ready_in = 1'b1;
        step();
        checks++;
        if (gnt_out !== 4'b1000 || sel_out !== 2'd3) begin
            errors++; $display("FAIL wd_grant got gnt=%b sel=%0d want 1000/3", gnt_out, sel_out);
        end
        step();
        step();
        req_in = 4'b0011;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL wd_valid got %b want 0", valid_out);
        end
        step();
        checks++;
        if (gnt_out !== 4'b0000) begin
            errors++; $display("FAIL wd_release got %b want 0000", gnt_out);
        end
        step();
        checks++;
        if (gnt_out !== 4'b0001 || sel_out !== 2'd0) begin
            errors++; $display("FAIL wd_wrap got gnt=%b sel=%0d want 0001/0", gnt_out, sel_out);
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        do_reset();
        req_in   = 4'b0001;
        ready_in = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt_out !== 4'b0000 || valid_out !== 1'b0 || sel_out !== 2'd0) begin
            errors++; $display("FAIL midrst got gnt=%b v=%b sel=%0d want 0000/0/0", gnt_out, valid_out, sel_out);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 10 && gnt_out != 4'b0000; c++) begin
            if (valid_out) beats++;
            step();
        end
        checks++;
        if (beats != 4) begin
            errors++; $display("FAIL midrst_fresh got %0d beats want 4", beats);
        end
    endtask

    task automatic test_random();
        logic [3:0]        exp_gnt;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_y;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req_in = 4'($urandom_range(0, 15));
            ready_in = ($urandom_range(0, 9) < 7);
            data_in  = (4*DATA_W)'($urandom);
            #1;
            exp_gnt   = m_busy ? 4'(1 << m_idx) : 4'b0000;
            exp_valid = m_busy && req_in[m_idx];
            exp_y     = data_in[m_sel*DATA_W +: DATA_W];
            checks++;
            if (gnt_out !== exp_gnt) begin
                errors++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gnt_out, exp_gnt);
            end
            checks++;
            if (sel_out !== 2'(m_sel)) begin
                errors++; $display("FAIL rnd_sel c=%0d got %0d want %0d", c, sel_out, m_sel);
            end
            checks++;
            if (valid_out !== exp_valid) begin
                errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, valid_out, exp_valid);
            end
            checks++;
            if (y_out !== exp_y) begin
                errors++; $display("FAIL rnd_y c=%0d got %h want %h", c, y_out, exp_y);
            end
            model_clock();
            step();
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        int ng = 0;
        logic [3:0] prev = 4'b0000;
        do_reset();
        req_in   = 4'b0001;
        ready_in = 1'b1;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            step();
            if (gnt_out != 4'b0000 && prev == 4'b0000) ng++;
            prev = gnt_out;
        end
        req_in = 4'b0000;
        step();
        checks++;
        if (ng != 5) begin
            errors++; $display("FAIL stats_grants got %0d want 5", ng);
        end
        checks++;
        if (grant_cnt_out !== {6'b000000, 2'b11}) begin
            errors++; $display("FAIL stats_cnt got %h want 03", grant_cnt_out);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        req_in   = 4'b0000;
        ready_in = 1'b0;
        data_in  = '0;
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_withdraw();
        test_reset_mid();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4x1.md
Name: rr_mux_arbiter_4x1

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 output mux among four requesters.
- Selects one requester, drives the mux select and a one-hot grant, and forwards the granted requester's data downstream under a valid/ready handshake.
- Bounds each grant to a maximum burst of beats.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- DATA_W, 8, width of each requester data word and of y_out.
- MAX_BURST, 4, maximum beats per grant (legal range 1..255).
- CNT_W, 8, width of each per-requester grant statistics counter (used only with ARB_STATS_EN).

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- req_in  input  4  request, bit i belongs to requester i.
- data_in  input  4*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- ready_in  input  1  downstream can accept a beat this cycle.
- gnt_out  output  4  one-hot grant (registered); all zero when idle.
- sel_out  output  2  mux select, index of the granted requester (registered).
- y_out  output  DATA_W  data_in slice chosen by sel_out (combinational mux of registered sel_out).
- valid_out  output  1  beat offered downstream.
- grant_cnt_out  output  4*CNT_W  grant counters; present only with ARB_STATS_EN.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, gnt_out=0, sel_out=0, round-robin pointer ptr=0, beat_cnt=0, valid_out=0, y_out=data_in slice 0.
  - Reset mid-grant aborts the burst immediately; no beat is counted.
- States: IDLE, GRANT.
- IDLE:
  - If req_in != 0, pick the first asserted bit searching ptr, ptr+1, ... modulo 4.
  - Register sel_out to that index and set gnt_out to its one-hot value.
  - Clear beat_cnt and go to GRANT.
  - Latency: request seen in cycle N, grant visible in cycle N+1.
  - If req_in == 0, stay in IDLE.
- GRANT:
  - valid_out = req_in[sel_out] (combinational).
  - Beat = valid_out && ready_in; on a beat, beat_cnt increments.
- Release occurs on either condition:
  - req_in[sel_out]==0 (requester withdrew; no beat that cycle), or
  - a beat with beat_cnt == MAX_BURST-1.
- On release:
  - gnt_out is cleared and ptr = sel_out+1 modulo 4 (3 wraps to 0).
  - Next state is IDLE; exactly one idle bubble separates consecutive grants.
- ready_in low holds the grant indefinitely; there is no timeout.
- MAX_BURST=1: every beat releases the grant.
- Requests from non-granted requesters are ignored until the next IDLE cycle; changes in their req_in never disturb the current grant.
- sel_out keeps its last value in IDLE, so y_out is stable while idle.
- Invariant: gnt_out has at most one bit set; gnt_out != 0 if and only if state==GRANT.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - grant_cnt_out exists.
  - Counter i increments by 1 each time requester i is granted (IDLE->GRANT transition).
  - Counters saturate at all-ones and reset to 0.
- Undefined: the port and all counter logic are absent; arbitration behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4 and SEL_W=2,
  - the state enum (IDLE, GRANT),
  - a function converting an index to one-hot.
- One natural sub-module, rr_pick4: combinational picker with inputs req[3:0] and ptr[1:0], outputs idx[1:0] and any.

Test Plan:
- Reset check: hold rst_n_in=0 with req_in=4'b1111 -> gnt_out=0, valid_out=0, sel_out=0. Assert reset mid-burst -> outputs clear in the same cycle without waiting for a clock edge.
- Single requester: req_in=4'b0100, ready_in=1, MAX_BURST=4 -> grant appears one cycle later with sel_out=2, gnt_out=4'b0100. Four beats carry data slice 2, then 1 idle cycle, then the grant is reissued to 2.
- All requesting: req_in=4'b1111, ready_in=1 -> grant order 0,1,2,3,0, each with 4 beats and one bubble between grants.
- Backpressure: grant to 1, ready_in=0 for 10 cycles -> valid_out=1 held and beat_cnt frozen. Then ready_in=1 -> exactly 4 beats, then release.
- Early withdrawal: grant to 3, req_in[3] drops after 2 beats -> release in that cycle, ptr wraps to 0, and the next grant goes to 0 if requesting.
- ARB_STATS_EN with CNT_W=2: grant requester 0 five times -> counter 0 reads 3 (saturated), other counters read 0.
